time_display_scan: RTL
======================

Name: time_display_scan

Overview:
- Consumes the 27-bit packed BCD time word that `clock_12hr` drives on `disp_time`, and drives a 6-digit multiplexed common-anode seven-segment display (hh mm ss).
- Snapshots the time once per scan frame, so a digit never mixes two times within one frame.
- Blanks the leading hour zero, blinks the colon, shows PM on a decimal point, and flags malformed time words.
- Sits between `clock_12hr` and the board display pins, on the same kilohertz clock.

Parameters:
- SCAN_DIV, 2: `kh_clk` cycles each digit stays lit. Legal range is 1 or more.

Ports:
- kh_clk  in  1  system clock (kilohertz domain).
- reset  in  1  synchronous, active-high reset.
- disp_time  in  27  packed time word:
  - [26] pm
  - [25:24] hour tens
  - [23:20] hour ones
  - [19:16] minute tens
  - [15:12] minute ones
  - [11:8] second tens
  - [7:4] second ones
  - [3:0] reserved, ignored
- an  out  6  digit enables, active-low, one-hot. Bit 0 is hour tens (leftmost); bit 5 is second ones.
- seg  out  7  segments, active-low, ordered {g,f,e,d,c,b,a}.
- dp  out  1  decimal point, active-low.
- frame_start  out  1  one-cycle pulse when digit 0 becomes active.
- time_err  out  1  high for the whole of any frame whose snapshot is invalid.

Behaviour:
- Clock and reset: one clock (`kh_clk`); reset is synchronous and active-high. All state changes on the rising edge of `kh_clk`.
- Reset values:
  - Outputs: an=6'h3F, seg=7'h7F, dp=1, frame_start=0, time_err=0.
  - Internal: div_cnt=0, idx=5, shadow=0.
  - Reset asserted mid-frame returns everything to these values at the next edge. The scan restarts from the reset state, and no partial frame resumes.
- Prescaler:
  - div_cnt counts 0..SCAN_DIV-1 and wraps.
  - tick is high when div_cnt==SCAN_DIV-1.
  - With SCAN_DIV=1, tick is high every cycle.
- Digit index:
  - On tick, idx advances 0→1→…→5→0.
  - On the tick where idx wraps 5→0, shadow loads disp_time. This is the only load point.
  - disp_time changes at any other time have no effect until the next wrap.
- Output stage:
  - an, seg, dp, frame_start and time_err are registered from the post-update idx and shadow.
  - They therefore lag the idx/shadow update by exactly 1 cycle.
  - After reset deasserts, an first goes active on edge SCAN_DIV+1.
- an equals ~(1<<idx).
- frame_start:
  - High for exactly one cycle: the first cycle an=6'b111110 in each frame.
  - Period is 6×SCAN_DIV cycles.
- Validity check on the shadow (all must hold):
  - hour tens ≤1
  - hour ones ≤9
  - hour value within 1..12
  - minute tens ≤5, minute ones ≤9
  - second tens ≤5, second ones ≤9
- Invalid frame:
  - time_err=1 for every cycle of the frame.
  - Every digit shows a dash, seg=7'h3F.
  - dp=1 on every digit.
  - The next valid snapshot clears time_err at the start of its frame.
- Seven-segment decode, active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19
  - 5=12, 6=02, 7=78, 8=00, 9=10 (hex)
- Digit 0 with hour tens equal to 0 is blanked, seg=7'h7F. The an bit still sequences normally.
- dp on a valid frame:
  - Colon: dp=0 on digits 1 and 3 when second ones bit 0 is 0 (even second), giving a 1 Hz blink.
  - PM: dp=0 on digit 5 when pm=1.
  - dp=1 in all other cases.

Test Plan:
- 12:34:56 PM (SCAN_DIV=2):
  - Stimulus: reset 3 cycles, then disp_time=27'h5234560.
  - Required: an steps 3E,3D,3B,37,2F,1F, each held 2 cycles.
  - seg sequence is 79,24,30,19,12,02.
  - dp=0 on digits 1, 3 and 5.
  - frame_start repeats every 12 cycles.
  - time_err=0.
- 09:05:07 AM:
  - Stimulus: disp_time=27'h0905070.
  - Required: digit 0 seg=7F; digits 1–5 seg = 10,40,12,40,78.
  - dp=1 on all digits (odd second, AM).
- Snapshot:
  - Stimulus: change disp_time from 27'h5234560 to 27'h5234570 while digit 2 is active.
  - Required: digit 5 keeps seg=02 in the current frame.
  - The next frame shows seg=78 on digit 5, and dp=1 on digits 1 and 3.
- Invalid time:
  - Stimulus: disp_time=27'h1300000 (13:00:00).
  - Required: time_err=1 for the full frame; all six digits seg=3F with dp=1.
  - After restoring 27'h5234560, time_err returns to 0 at the next frame_start.
- Reset mid-frame:
  - Stimulus: assert reset while an=37.
  - Required: next edge gives an=3F, seg=7F, dp=1, frame_start=0.
  - After release, first frame_start occurs at edge SCAN_DIV+1.
- SCAN_DIV sweep:
  - Stimulus: run with SCAN_DIV=1 and with SCAN_DIV=4.
  - Required: frame_start period is 6 cycles and 24 cycles respectively.
  - Each an value is held 1 cycle and 4 cycles respectively.

Source files
------------

// File: rtl/time_display_scan_if.sv
// Bundles the time word from the clock source with the multiplexed display pins.
// master drives disp_time and observes the pins; slave is the scanner.
interface time_display_scan_if;
    logic [26:0] disp_time;
    logic [5:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;
    logic        time_err;

    modport master (output disp_time, input an, seg, dp, frame_start, time_err);
    modport slave  (input disp_time, output an, seg, dp, frame_start, time_err);
endinterface

// File: rtl/time_display_scan.sv
// Scans a 6-digit common-anode display from a per-frame snapshot of the BCD time word.
// Outputs lag the digit index by 1 cycle; free-running, no backpressure.
module time_display_scan #(
    parameter int SCAN_DIV = 2
) (
    input  logic               kh_clk,
    input  logic               reset,
    time_display_scan_if.slave disp
);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [26:0]      shadow_q, shadow_d;
    logic             loaded_q, loaded_d;
    logic             live_q, live_d;
    logic [5:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             frame_start_q, frame_start_d;
    logic             time_err_q, time_err_d;

    logic       tick, wrap, valid, hour_ok;
    logic       pm;
    logic [1:0] h_tens;
    logic [3:0] h_ones, m_tens, m_ones, s_tens, s_ones, digit;
    logic       unused_rsvd;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    assign pm          = shadow_q[26];
    assign h_tens      = shadow_q[25:24];
    assign h_ones      = shadow_q[23:20];
    assign m_tens      = shadow_q[19:16];
    assign m_ones      = shadow_q[15:12];
    assign s_tens      = shadow_q[11:8];
    assign s_ones      = shadow_q[7:4];
    assign unused_rsvd = ^shadow_q[3:0];

    // Hour must read 01..12; this also bounds the tens and ones digits.
    assign hour_ok = ((h_tens == 2'd0) && (h_ones >= 4'd1) && (h_ones <= 4'd9)) ||
                     ((h_tens == 2'd1) && (h_ones <= 4'd2));
    assign valid   = hour_ok && (m_tens <= 4'd5) && (m_ones <= 4'd9) &&
                     (s_tens <= 4'd5) && (s_ones <= 4'd9);

    always_comb begin
        tick      = (div_cnt_q == DIV_MAX);
        wrap      = tick && (idx_q == 3'd5);
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        idx_d     = idx_q;
        if (tick) begin
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end
        shadow_d = wrap ? disp.disp_time : shadow_q;
        loaded_d = wrap;
        live_d   = live_q | wrap;
    end

    always_comb begin
        case (idx_q)
            3'd0:    digit = {2'b00, h_tens};
            3'd1:    digit = h_ones;
            3'd2:    digit = m_tens;
            3'd3:    digit = m_ones;
            3'd4:    digit = s_tens;
            default: digit = s_ones;
        endcase

        an_d          = 6'h3F;
        seg_d         = 7'h7F;
        dp_d          = 1'b1;
        frame_start_d = 1'b0;
        time_err_d    = 1'b0;
        // Display stays dark until the first snapshot has been taken.
        if (live_q) begin
            an_d          = ~(6'b000001 << idx_q);
            frame_start_d = loaded_q;
            if (!valid) begin
                seg_d      = 7'h3F;
                time_err_d = 1'b1;
            end else begin
                seg_d = ((idx_q == 3'd0) && (h_tens == 2'd0)) ? 7'h7F : seg7(digit);
                case (idx_q)
                    3'd1, 3'd3: dp_d = s_ones[0];
                    3'd5:       dp_d = ~pm;
                    default:    dp_d = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge kh_clk) begin
        if (reset) begin
            div_cnt_q     <= '0;
            idx_q         <= 3'd5;
            shadow_q      <= '0;
            loaded_q      <= 1'b0;
            live_q        <= 1'b0;
            an_q          <= 6'h3F;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
            frame_start_q <= 1'b0;
            time_err_q    <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            loaded_q      <= loaded_d;
            live_q        <= live_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            frame_start_q <= frame_start_d;
            time_err_q    <= time_err_d;
        end
    end

    assign disp.an          = an_q;
    assign disp.seg         = seg_q;
    assign disp.dp          = dp_q;
    assign disp.frame_start = frame_start_q;
    assign disp.time_err    = time_err_q;
endmodule
